storebyte_rmw: RTL
==================

// Module: storebyte_rmw
// PURPOSE
//  Store-side counterpart to the byte-load path of the multicycle datapath.
//  - Writes an 8-bit byte (SB) or a full 16-bit word (SW) into word-wide (16-bit) data memory.
//  - The memory has no byte enables, so SB is a read-modify-write: read word, replace one lane, write back.
//  - Sits between the control FSM (start/done handshake) and the data-memory port.
// PARAMETERS
//  ADDR_W   16  byte-address width; word address = addr[ADDR_W-1:1]
//  MEM_LAT  1   cycles from mem_rd_en high to valid mem_rdata (legal range 1..15)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        synchronous, active-low reset
//  start      in   1        request; sampled only in IDLE
//  st_word    in   1        1 = SW (16-bit store), 0 = SB (byte store)
//  addr       in   ADDR_W   byte address; bit0 = lane (0 = data[7:0], 1 = data[15:8])
//  wdata      in   16       store data; SB uses wdata[7:0] only
//  busy       out  1        high from the cycle after accept through the WR cycle
//  done       out  1        one-cycle pulse, coincident with mem_wr_en
//  mem_addr   out  ADDR_W-1 word address to memory
//  mem_rd_en  out  1        one-cycle read strobe
//  mem_rdata  in   16       read data, valid MEM_LAT cycles after mem_rd_en
//  mem_wr_en  out  1        one-cycle write strobe
//  mem_wdata  out  16       write data
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, mem_rd_en, mem_wr_en = 0; mem_addr, mem_wdata = 0.
//  - All outputs registered.
//  - Accept: start=1 in IDLE at edge E.
//    - addr, wdata, st_word latched at E.
//    - mem_addr = latched addr[ADDR_W-1:1].
//    - start while busy is ignored; it is not queued.
//  - States: IDLE, RD, WAIT, WR.
//    - IDLE -> WR if start & st_word; mem_wdata = wdata. Latency: WR in cycle E+1.
//    - IDLE -> RD if start & !st_word.
//    - RD: mem_rd_en = 1 for exactly one cycle -> WAIT. Load 4-bit counter with MEM_LAT-1.
//    - WAIT: decrement the counter. When it is 0, capture mem_rdata and merge -> WR.
//      - lane0: {rdata[15:8], byte}; lane1: {byte, rdata[7:0]}.
//    - WR: mem_wr_en = 1 and done = 1 for exactly one cycle -> IDLE. busy falls the next cycle.
//    - SB latency (MEM_LAT=1): RD in E+1, WAIT in E+2, WR/done in E+3.
//      General case: done in cycle E+2+MEM_LAT.
//  - start in the WR cycle is ignored. A new request can be accepted from the IDLE cycle after done.
//  - mem_addr and mem_wdata hold their values until the next accept. No X on outputs after reset.
//  - Reset mid-operation:
//    - The next edge forces IDLE and clears all strobes.
//    - A write in progress at that edge completes its single strobe cycle only.
//    - No write is issued for an aborted SB.
//  - Address wrap: the word address is a plain truncation. Max address 0xFFFF -> word 0x7FFF, lane1. No carry.
//  - mem_rd_en and mem_wr_en are never high in the same cycle.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles with start=1 -> all outputs 0, no strobes, busy=0.
//  2. SB lane0, MEM_LAT=1: mem[0x0010] = 0xABCD; start, addr=0x0020, wdata=0x0012
//     -> rd_en at E+1, wr_en/done at E+3, mem_addr=0x0010, mem_wdata=0xAB12.
//  3. SB lane1: mem[0x0010] = 0xABCD; addr=0x0021, wdata=0x00EF
//     -> mem_wdata=0xEFCD, mem_rd_en exactly 1 cycle.
//  4. SW: addr=0x0041, wdata=0x1234 -> no rd_en, wr_en/done at E+1,
//     mem_addr=0x0020, mem_wdata=0x1234 (bit0 ignored).
//  5. start held high through an SB -> exactly one RD/WR pair;
//     second accept happens in the IDLE cycle after done.
//  6. MEM_LAT=3, SB, addr=0xFFFF, wdata=0x0055, mem=0x1111
//     -> done at E+5, mem_addr=0x7FFF, mem_wdata=0x5511.
//     Repeat with rst_n=0 in WAIT -> no wr_en, IDLE next cycle.

Source files
------------

// File: rtl/storebyte_rmw_if.sv
// Bundles the store-request handshake and the word-wide data-memory port of storebyte_rmw.
// The slave modport is the store unit itself; master is the controller/memory side.
interface storebyte_rmw_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              st_word;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W-2:0] mem_addr;
  logic              mem_rd_en;
  logic [15:0]       mem_rdata;
  logic              mem_wr_en;
  logic [15:0]       mem_wdata;

  modport slave (
    input  start, st_word, addr, wdata, mem_rdata,
    output busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );

  modport master (
    output start, st_word, addr, wdata, mem_rdata,
    input  busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );
endinterface

// File: rtl/storebyte_rmw.sv
// Byte/word store unit for a 16-bit word memory without byte enables.
// SW writes straight through; SB reads the word, replaces one lane, and writes it back.
module storebyte_rmw #(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  storebyte_rmw_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_lane;
  logic [7:0]        r_byte;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic              r_wr_en;
  logic [ADDR_W-2:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make the merge see a half-updated FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_lane      <= 1'b0;
      r_byte      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mem_addr <= bus.addr[ADDR_W-1:1];
            r_lane     <= bus.addr[0];
            r_byte     <= bus.wdata[7:0];
            r_busy     <= 1'b1;
            if (bus.st_word) begin
              r_mem_wdata <= bus.wdata;
              r_wr_en     <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= WR;
            end else begin
              r_rd_en <= 1'b1;
              r_state <= RD;
            end
          end
        end
        RD: begin
          r_rd_en <= 1'b0;
          r_cnt   <= LAT_M1;
          r_state <= WAIT;
        end
        WAIT: begin
          // Counter reaches zero in the cycle mem_rdata becomes valid.
          if (r_cnt == 4'd0) begin
            r_mem_wdata <= r_lane ? {r_byte, bus.mem_rdata[7:0]}
                                  : {bus.mem_rdata[15:8], r_byte};
            r_wr_en     <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= WR;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WR: begin
          r_wr_en <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_rd_en = r_rd_en;
  assign bus.mem_wr_en = r_wr_en;
  assign bus.mem_wdata = r_mem_wdata;
endmodule
